// File: rtl/seq_pattern_tx_if.sv
// seq_pattern_tx_if: control/data bundle between a pattern source controller
// (master) and the serial pattern transmitter (slave).
//   load      start request, honoured only while ready=1
//   data      parallel pattern, frame sent data[L-1] .. data[0]
//   len       frame length L (0 or >WIDTH selects WIDTH)
//   rpt       restart the frame with no gap while high
//   abort     terminate the current frame
//   outp      serial bit
//   out_valid outp carries a frame bit
//   done      pulse on the last bit of each frame pass
//   ready     idle and able to accept load
interface seq_pattern_tx_if #(
    parameter int WIDTH = 17,
    parameter int CNT_W = 5
);
    logic             load;
    logic [WIDTH-1:0] data;
    logic [CNT_W-1:0] len;
    logic             rpt;
    logic             abort;
    logic             outp;
    logic             out_valid;
    logic             done;
    logic             ready;

    modport master (
        output load, data, len, rpt, abort,
        input  outp, out_valid, done, ready
    );

    modport slave (
        input  load, data, len, rpt, abort,
        output outp, out_valid, done, ready
    );
endinterface

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: captures a parallel pattern and shifts it out one bit per
// clock, first bit data[L-1], last bit data[0]. Supports variable length,
// gapless repeat and abort. All outputs are registered.
//   clk  rising-edge clock
//   rst  synchronous active-low reset
//   bus  seq_pattern_tx_if.slave (load/data/len/rpt/abort in,
//        outp/out_valid/done/ready out)
module seq_pattern_tx #(
    parameter int WIDTH = 17,
    parameter int CNT_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    seq_pattern_tx_if.slave   bus
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;      // bits still to be sent, next one at MSB
    logic [WIDTH-1:0] r_hold_pat;   // MSB-aligned frame, reused on repeat
    logic [CNT_W-1:0] r_cnt;        // bits remaining after the current one
    logic [CNT_W-1:0] r_hold_cnt;   // L-1, reused on repeat
    logic             r_outp;
    logic             r_valid;
    logic             r_done;
    logic             r_ready;

    logic [CNT_W-1:0] w_eff_len;
    logic [CNT_W-1:0] w_shamt;
    logic [WIDTH-1:0] w_aligned;

    // Left-align the frame so that every length shifts out of the same MSB.
    assign w_eff_len = (bus.len == '0 || bus.len > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : bus.len;
    assign w_shamt   = CNT_W'(WIDTH) - w_eff_len;
    assign w_aligned = bus.data << w_shamt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_hold_pat <= '0;
            r_cnt      <= '0;
            r_hold_cnt <= '0;
            r_outp     <= 1'b0;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
            r_ready    <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    // abort is meaningless here and must not block load
                    if (bus.load) begin
                        r_state    <= SEND;
                        r_hold_pat <= w_aligned;
                        r_hold_cnt <= w_eff_len - CNT_W'(1);
                        r_outp     <= w_aligned[WIDTH-1];
                        r_shift    <= w_aligned << 1;
                        r_cnt      <= w_eff_len - CNT_W'(1);
                        r_valid    <= 1'b1;
                        r_ready    <= 1'b0;
                        r_done     <= (w_eff_len == CNT_W'(1));
                    end
                end
                SEND: begin
                    if (bus.abort) begin
                        r_state <= IDLE;
                        r_outp  <= 1'b0;
                        r_valid <= 1'b0;
                        r_done  <= 1'b0;
                        r_ready <= 1'b1;
                    end else if (r_cnt != '0) begin
                        r_outp  <= r_shift[WIDTH-1];
                        r_shift <= r_shift << 1;
                        r_cnt   <= r_cnt - CNT_W'(1);
                        // done is registered, so raise it one edge early
                        r_done  <= (r_cnt == CNT_W'(1));
                    end else if (bus.rpt) begin
                        // restart from the held copy; live data/len are ignored
                        r_outp  <= r_hold_pat[WIDTH-1];
                        r_shift <= r_hold_pat << 1;
                        r_cnt   <= r_hold_cnt;
                        r_done  <= (r_hold_cnt == '0);
                    end else begin
                        r_state <= IDLE;
                        r_outp  <= 1'b0;
                        r_valid <= 1'b0;
                        r_done  <= 1'b0;
                        r_ready <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.outp      = r_outp;
    assign bus.out_valid = r_valid;
    assign bus.done      = r_done;
    assign bus.ready     = r_ready;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx: directed scenarios plus randomized traffic, all compared
// against a frame-level reference model (bit list + position).
module tb_seq_pattern_tx;
    localparam int WIDTH = 17;
    localparam int CNT_W = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    seq_pattern_tx_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    seq_pattern_tx #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // reference model: frame as an ordered bit list, current position
    bit m_busy = 1'b0;
    bit m_seq [0:WIDTH-1];
    int m_len = 1;
    int m_pos = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task model_edge();
        int l;
        if (!rst) begin
            m_busy = 1'b0;
        end else if (!m_busy) begin
            if (bus.load) begin
                l = (int'(bus.len) == 0 || int'(bus.len) > WIDTH) ? WIDTH : int'(bus.len);
                m_len = l;
                for (int k = 0; k < l; k++) m_seq[k] = bus.data[l-1-k];
                m_pos  = 0;
                m_busy = 1'b1;
            end
        end else if (bus.abort) begin
            m_busy = 1'b0;
        end else if (m_pos == m_len - 1) begin
            if (bus.rpt) m_pos = 0;
            else         m_busy = 1'b0;
        end else begin
            m_pos++;
        end
    endtask

    task cycle(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk({tag, ".valid"}, 32'(bus.out_valid), 32'(m_busy));
        chk({tag, ".outp"},  32'(bus.outp),      32'(m_busy ? m_seq[m_pos] : 1'b0));
        chk({tag, ".done"},  32'(bus.done),      32'(m_busy && m_pos == m_len - 1));
        chk({tag, ".ready"}, 32'(bus.ready),     32'(!m_busy));
    endtask

    task start(input logic [WIDTH-1:0] d, input logic [CNT_W-1:0] l, input logic r);
        bus.data = d;
        bus.len  = l;
        bus.rpt  = r;
        bus.load = 1'b1;
        cycle("start");
        bus.load = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] pat;
        logic [9:0]       exp10;
        logic [4:0]       win;
        int               hits;
        int               nval;

        bus.load = 1'b0; bus.data = '0; bus.len = '0; bus.rpt = 1'b0; bus.abort = 1'b0;
        rst = 1'b0;
        cycle("rst");
        cycle("rst");
        rst = 1'b1;
        cycle("idle");

        // full-width frame, fed into a 10110 detector
        pat  = 17'b01101101010101100;
        win  = '0;
        hits = 0;
        start(pat, 5'd0, 1'b0);
        for (int c = 1; c <= 18; c++) begin
            if (c > 1) cycle("t1");
            if (c <= 17) begin
                chk("t1.bit", 32'(bus.outp), 32'(pat[WIDTH-c]));
                win = {win[3:0], bus.outp};
                if (win == 5'b10110) hits++;
            end
            chk("t1.done", 32'(bus.done), 32'(c == 17));
        end
        chk("t1.ready18", 32'(bus.ready), 32'd1);
        chk("t1.hits", 32'(hits), 32'd2);

        // repeat two passes, gapless
        exp10 = 10'b1011010110;
        start({12'hA5C, 5'b10110}, 5'd5, 1'b1);
        for (int c = 1; c <= 11; c++) begin
            if (c > 1) cycle("t2");
            if (c <= 10) chk("t2.bit", 32'(bus.outp), 32'(exp10[10-c]));
            chk("t2.done", 32'(bus.done), 32'(c == 5 || c == 10));
            if (c == 6) bus.rpt = 1'b0;
        end
        chk("t2.idle11", 32'(bus.out_valid), 32'd0);

        // load during SEND with new data/len is ignored
        start(17'h1F0F3, 5'd8, 1'b0);
        for (int c = 2; c <= 9; c++) begin
            if (c == 3) begin bus.load = 1'b1; bus.data = 17'h0AAAA; bus.len = 5'd3; end
            if (c == 6) bus.load = 1'b0;
            cycle("t3");
        end
        bus.load = 1'b0;
        cycle("t3");

        // abort in cycle 3
        start(17'h1FFFF, 5'd0, 1'b0);
        cycle("t4"); cycle("t4");
        bus.abort = 1'b1;
        cycle("t4ab");
        bus.abort = 1'b0;
        chk("t4.abort_valid", 32'(bus.out_valid), 32'd0);
        chk("t4.abort_ready", 32'(bus.ready), 32'd1);
        cycle("t4");

        // reset in cycle 6
        start(17'h1FFFF, 5'd0, 1'b1);
        for (int c = 2; c <= 6; c++) cycle("t4r");
        rst = 1'b0;
        cycle("t4rst");
        rst = 1'b1;
        chk("t4.rst_valid", 32'(bus.out_valid), 32'd0);
        chk("t4.rst_ready", 32'(bus.ready), 32'd1);
        bus.rpt = 1'b0;
        cycle("t4");

        // single-bit frame, then single-bit repeat
        start(17'h00001, 5'd1, 1'b0);
        chk("t5.len1_bit", 32'(bus.outp), 32'd1);
        chk("t5.len1_done", 32'(bus.done), 32'd1);
        cycle("t5");
        start(17'h00001, 5'd1, 1'b1);
        for (int c = 0; c < 4; c++) begin
            cycle("t5r");
            chk("t5.rpt_done", 32'(bus.done), 32'd1);
        end
        bus.rpt = 1'b0;
        cycle("t5");

        // len > WIDTH sends WIDTH bits
        nval = 0;
        start(17'h15A3C, 5'd20, 1'b0);
        for (int c = 1; c <= 18; c++) begin
            if (c > 1) cycle("t5w");
            if (bus.out_valid) nval++;
        end
        chk("t5.len20_count", 32'(nval), 32'd17);

        // back-to-back: reload in the first ready cycle
        start(17'h0002D, 5'd6, 1'b0);
        for (int c = 2; c <= 7; c++) cycle("t6");
        chk("t6.ready", 32'(bus.ready), 32'd1);
        start(17'h00013, 5'd5, 1'b0);
        chk("t6.first_bit", 32'(bus.outp), 32'd1);
        for (int c = 2; c <= 6; c++) cycle("t6b");

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 199) != 0);
            bus.load  = ($urandom_range(0, 3) == 0);
            bus.data  = WIDTH'($urandom);
            bus.len   = CNT_W'($urandom_range(0, 31));
            bus.rpt   = ($urandom_range(0, 3) == 0);
            bus.abort = ($urandom_range(0, 29) == 0);
            cycle("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
